// File: rtl/shift_delay_line.sv
// shift_delay_line: parametrised multi-stage shift register.
// Supports four operating modes: hold, shift, rotate and synchronous flush.
// A runtime-selectable output tap reads any stage.
// A fill counter tracks how many stages currently hold valid data.
// Stage 0 is the newest word; stage DEPTH-1 is the oldest and drives so.
module shift_delay_line #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int TAPW  = $clog2(DEPTH),
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] si,
    input  logic [TAPW-1:0]  tap,
    output logic [WIDTH-1:0] so,
    output logic [WIDTH-1:0] so_tap,
    output logic             tap_valid,
    output logic [CNTW-1:0]  fill,
    output logic             full,
    output logic             empty
);

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_SHIFT  = 2'b01,
        MODE_ROTATE = 2'b10,
        MODE_FLUSH  = 2'b11
    } mode_e;

    localparam logic [CNTW-1:0] FILL_MAX = CNTW'(DEPTH);

    logic [WIDTH-1:0] r_stage [DEPTH];
    logic [CNTW-1:0]  r_fill;

    logic [WIDTH-1:0] w_stage_nxt [DEPTH];
    logic [CNTW-1:0]  w_fill_nxt;
    logic             w_full;
    mode_e            w_mode;
    logic [WIDTH-1:0] w_so_tap;

    assign w_mode = mode_e'(mode);
    assign w_full = (r_fill == FILL_MAX);

    // Next-state decode of stage contents and fill count for the selected mode
    always_comb begin
        w_fill_nxt = r_fill;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_stage_nxt[i] = r_stage[i];
        end
        unique case (w_mode)
            MODE_SHIFT: begin
                w_stage_nxt[0] = si;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    w_stage_nxt[i] = r_stage[i-1];
                end
                if (!w_full) begin
                    w_fill_nxt = r_fill + CNTW'(1);
                end
            end
            MODE_ROTATE: begin
                // Only recirculate when every stage is valid; otherwise act as hold
                if (w_full) begin
                    w_stage_nxt[0] = r_stage[DEPTH-1];
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        w_stage_nxt[i] = r_stage[i-1];
                    end
                end
            end
            MODE_FLUSH: begin
                w_fill_nxt = '0;
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    w_stage_nxt[i] = '0;
                end
            end
            default: begin
                w_fill_nxt = r_fill;
            end
        endcase
    end

    // Stage and fill registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fill <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_fill <= w_fill_nxt;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_stage[i] <= w_stage_nxt[i];
            end
        end
    end

    // Tap multiplexer; out-of-range tap indices read as zero
    always_comb begin
        w_so_tap = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (32'(tap) == i) begin
                w_so_tap = r_stage[i];
            end
        end
    end

    assign so        = r_stage[DEPTH-1];
    assign so_tap    = w_so_tap;
    // fill never exceeds DEPTH, so an out-of-range tap is never valid
    assign tap_valid = (32'(tap) < 32'(r_fill));
    assign fill      = r_fill;
    assign full      = w_full;
    assign empty     = (r_fill == '0);

endmodule

// File: doc/shift_delay_line.md
# shift_delay_line

Parametrised multi-stage shift register with a shift enable. Widths are configurable. On top of plain shifting it has an explicit operating mode (hold, shift, rotate, synchronous flush), a runtime-selectable output tap, and a fill counter that reports how many stages hold valid data. It sits in datapaths that need a programmable delay or a circular sample buffer, and is the generalised successor of the team's fixed 4-bit x 8-stage shifter.

## Interface
Parameters:
- WIDTH, 4, bits per stage (>=1)
- DEPTH, 8, number of stages (>=2)
- TAPW, $clog2(DEPTH), width of tap select
- CNTW, $clog2(DEPTH+1), width of fill count

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high; clears all stages and fill
- mode  in  2  00 hold, 01 shift, 10 rotate, 11 flush
- si  in  WIDTH  serial input word, sampled on shift
- tap  in  TAPW  stage index driven onto so_tap
- so  out  WIDTH  stage DEPTH-1 (oldest word)
- so_tap  out  WIDTH  stage[tap], combinational from stages and tap
- tap_valid  out  1  stage[tap] holds valid data (fill > tap)
- fill  out  CNTW  number of valid stages, 0..DEPTH
- full  out  1  fill == DEPTH
- empty  out  1  fill == 0

## Operation
- Storage: DEPTH registers stage[0..DEPTH-1], each WIDTH bits. Stage 0 is the newest word and stage DEPTH-1 the oldest.
- Mode 00 (hold): no state changes.
- Mode 01 (shift):
  - stage[0] <= si; stage[i] <= stage[i-1] for i = 1..DEPTH-1.
  - The old stage[DEPTH-1] is discarded.
  - fill <= min(fill+1, DEPTH), saturating at DEPTH.
- Mode 10 (rotate):
  - Applies only when full = 1: stage[0] <= stage[DEPTH-1]; stage[i] <= stage[i-1]; fill unchanged.
  - When full = 0, rotate is ignored and behaves exactly as hold. Invalid stages are never recirculated.
- Mode 11 (flush): all stages <= 0 and fill <= 0 on the clock edge (synchronous clear).
- Tap select:
  - so_tap = stage[tap] when tap <= DEPTH-1.
  - When tap >= DEPTH (possible for non-power-of-2 DEPTH), so_tap = 0 and tap_valid = 0.
- tap_valid = (tap < fill). full and empty are decoded combinationally from fill.

## Timing
- Reset values: all stages 0, so = 0, so_tap = 0, fill = 0, full = 0, empty = 1, tap_valid = 0.
- Reset behaviour:
  - rst takes effect immediately (asynchronous), regardless of mode.
  - Deasserting rst mid-stream restarts from empty; no partial state survives.
- Shift latency:
  - A word presented on si with mode=01 at edge n is in stage[k] after edge n+k.
  - It appears on so after DEPTH shift edges in total.
  - Hold cycles between shifts add no stage movement.
- fill and full reflect the registered state. They update on the same edge as the stage contents, with no extra cycle.
- Outputs so, fill, full and empty are registered or pure decodes of registers. so_tap and tap_valid are combinational from tap, so a tap change is visible in the same cycle.
- Shift while full: fill stays DEPTH and the oldest word is dropped. No overflow flag.
- mode is sampled every edge. There is no handshake and no multi-cycle operation.

## Test plan
- Reset and fill: assert rst mid-cycle with stages non-zero -> all outputs 0 at once and empty = 1. Then shift si = 1..8 (WIDTH = 4, DEPTH = 8) -> fill steps 1..8, full = 1 after the 8th edge, so = 1.
- Latency and tap: after that fill, sweep tap 0..7 -> so_tap = 8,7,...,1 with tap_valid = 1. One more shift of 9 -> so = 2, fill stays 8.
- Partial fill: from reset, shift 3 words (A, B, C) -> fill = 3; tap = 2 gives so_tap = A, tap_valid = 1; tap = 3 gives tap_valid = 0. Rotate for 2 cycles -> no change, since not full.
- Rotate: full with stages 8..1 (so = 1), rotate once -> stage[0] = 1 and so = 2. After 8 rotates -> original contents restored, fill = 8.
- Flush and hold: full register, mode = 00 for 5 cycles -> no change. mode = 11 for 1 cycle -> fill = 0, empty = 1, all stages 0. Then shift 5 -> stage[0] = 5, fill = 1.
- Non-power-of-2: DEPTH = 5, WIDTH = 8, tap = 6 -> so_tap = 0 and tap_valid = 0. Shift 0xAA five times -> full = 1 and so = 0xAA after the 5th edge.
